// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared types and helpers for the bit-serial arithmetic blocks.
//   state_t   : serial-engine FSM states (IDLE / RUN / DONE)
//   cnt_width : width of a bit counter that has to reach n-1 (at least 1)
// ---------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A 1- or 2-bit operand still needs a 1-bit counter; $clog2 would return 0 for n=1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Operand and result handshake bundle for serial_subtractor.
//   master : producer/consumer side (drives operands, output_ready)
//   slave  : subtractor side (drives input_ready and the result)
// Parameter N : operand/result width.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int N = 8
);
  logic         input_valid;
  logic         input_ready;
  logic [N-1:0] input_a;
  logic [N-1:0] input_b;
  logic         input_borrow;
  logic         output_valid;
  logic         output_ready;
  logic [N-1:0] output_diff;
  logic         output_borrow;
  logic         output_overflow;

  modport master (
    output input_valid, input_a, input_b, input_borrow, output_ready,
    input  input_ready, output_valid, output_diff, output_borrow, output_overflow
  );

  modport slave (
    input  input_valid, input_a, input_b, input_borrow, output_ready,
    output input_ready, output_valid, output_diff, output_borrow, output_overflow
  );
endinterface

// File: rtl/full_subtractor_bit.sv
// ---------------------------------------------------------------------------
// full_subtractor_bit
// Combinational 1-bit full subtractor cell: computes a - b - borrow_i.
//   a_i, b_i   : operand bits
//   borrow_i   : borrow in
//   diff_o     : difference bit
//   borrow_o   : borrow out
// ---------------------------------------------------------------------------
module full_subtractor_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic borrow_i,
  output logic diff_o,
  output logic borrow_o
);
  assign diff_o   = a_i ^ b_i ^ borrow_i;
  // Borrow when b exceeds a outright, or when they are equal and a borrow is pending.
  assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);
endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial N-bit two's-complement subtractor: diff = a - b - borrow_in,
// one bit per clock (LSB first) through a single full_subtractor_bit cell.
// One result every N+2 cycles when the consumer keeps output_ready high.
//
// Ports
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : serial_subtractor_if.slave (operand and result handshakes)
// Parameter
//   N   : operand/result width (>= 1)
// Build option
//   SERIAL_SUBTRACTOR_OVERFLOW_EN : when defined, operand sign bits are
//   captured at accept and output_overflow reports signed overflow;
//   otherwise output_overflow is tied low.
// ---------------------------------------------------------------------------
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input logic           clk,
  input logic           rst,
  serial_subtractor_if.slave bus
);

  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic          br_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;
  logic          ready_q;

  logic          cell_diff;
  logic          cell_borrow;
  logic [N:0]    res_cat;

  full_subtractor_bit u_cell (
    .a_i      (a_q[0]),
    .b_i      (b_q[0]),
    .borrow_i (br_q),
    .diff_o   (cell_diff),
    .borrow_o (cell_borrow)
  );

  // New difference bit enters at the MSB; after N shifts bit 0 sits at the LSB.
  // Building it as a concatenation keeps the slice legal for N=1.
  assign res_cat = {cell_diff, res_q};

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic a_sign_q;
  logic b_sign_q;
  logic ovf_q;
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.input_valid) begin
            a_q     <= bus.input_a;
            b_q     <= bus.input_b;
            br_q    <= bus.input_borrow;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_sign_q <= bus.input_a[N-1];
            b_sign_q <= bus.input_b[N-1];
`endif
          end
        end

        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= cell_borrow;
          res_q <= res_cat[N:1];
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            valid_q <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            // cell_diff is the result MSB on the final bit.
            ovf_q <= (a_sign_q ^ b_sign_q) & (cell_diff ^ a_sign_q);
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DONE: begin
          if (bus.output_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // ready_q already reads 1 in the reset cycle of an idle engine; mask it so
  // no operand is offered acceptance while reset is asserted.
  assign bus.input_ready   = ready_q & ~rst;
  assign bus.output_valid  = valid_q;
  assign bus.output_diff   = res_q;
  assign bus.output_borrow = br_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign bus.output_overflow = ovf_q;
`else
  assign bus.output_overflow = 1'b0;
`endif

endmodule
